// File: rtl/i2s_tdm_clock_gen.sv
// i2s_tdm_clock_gen: runtime-configurable I2S / TDM serial-audio clock master.
// Generates SCK with exact 50% duty from a half-period divider. It also generates
// WS (I2S word select or TDM frame-sync pulse), SCK edge strobes, and slot/bit
// position outputs for downstream serialisers. Divider, mode and slot count
// are latched at each frame start, so a change in the middle of a frame
// waits for the next frame boundary.
module i2s_tdm_clock_gen #(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned MAX_SLOTS = 8,
  parameter logic        WS_POL    = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic [DIV_W-1:0]             div_i,
  input  logic                         tdm_i,
  input  logic [$clog2(MAX_SLOTS)-1:0] nslots_m1_i,
  output logic                         sck_o,
  output logic                         ws_o,
  output logic                         frame_start_o,
  output logic                         sck_rise_o,
  output logic                         sck_fall_o,
  output logic [$clog2(MAX_SLOTS)-1:0] slot_o,
  output logic [$clog2(SLOT_BITS)-1:0] bit_o,
  output logic                         active_o
);

  localparam int unsigned SLOT_W = $clog2(MAX_SLOTS);
  localparam int unsigned BIT_W  = $clog2(SLOT_BITS);

  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(SLOT_BITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_STOP_PEND = 2'd2;

  // Control state and latched frame configuration
  logic [1:0]        r_state;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_dm1;
  logic              r_tdm;
  logic [SLOT_W-1:0] r_last;

  // Registered outputs
  logic              r_sck;
  logic              r_ws;
  logic              r_fs;
  logic              r_rise;
  logic              r_fall;
  logic [SLOT_W-1:0] r_slot;
  logic [BIT_W-1:0]  r_bit;
  logic              r_active;

  // Combinational next-position and event decode
  logic [DIV_W-1:0]  w_dm1_in;
  logic [SLOT_W-1:0] w_last_in;
  logic              w_ws_idle;
  logic              w_term;
  logic              w_bit_wrap;
  logic              w_slot_wrap;
  logic [BIT_W-1:0]  w_nbit;
  logic [SLOT_W-1:0] w_nslot;
  logic              w_boundary;
  logic              w_stop;
  logic              w_ws_frame;
  logic              w_ws_next;

  // WS level for a given position. In I2S mode WS leads each slot by one bit.
  // In TDM mode WS is high during the last bit of the last slot.
  function automatic logic ws_calc(
    input logic              tdm,
    input logic [SLOT_W-1:0] last,
    input logic [SLOT_W-1:0] slot,
    input logic [BIT_W-1:0]  bitn
  );
    logic alt;
    if (tdm) begin
      return (slot == last) && (bitn == BIT_LAST);
    end
    alt = ((slot == SLOT_ONE) && (bitn != BIT_LAST)) ||
          ((slot == '0) && (bitn == BIT_LAST));
    return alt ? ~WS_POL : WS_POL;
  endfunction

  // Decode the divider terminal count, the next bit/slot position and frame events
  always_comb begin
    w_dm1_in    = (div_i == '0) ? '0 : div_i - DIV_W'(1);
    w_last_in   = tdm_i ? nslots_m1_i : SLOT_ONE;
    w_ws_idle   = tdm_i ? 1'b0 : WS_POL;
    w_term      = (r_cnt == r_dm1);
    w_bit_wrap  = (r_bit == BIT_LAST);
    w_slot_wrap = w_bit_wrap && (r_slot == r_last);
    w_nbit      = w_bit_wrap ? '0 : r_bit + BIT_W'(1);
    w_nslot     = r_slot;
    if (w_bit_wrap) begin
      w_nslot = (r_slot == r_last) ? '0 : r_slot + SLOT_W'(1);
    end
    // A frame boundary is an SCK fall where both slot and bit wrap
    w_boundary  = (r_state != ST_IDLE) && w_term && r_sck && w_slot_wrap;
    w_stop      = w_boundary && (r_state == ST_STOP_PEND) && !en_i;
    // At a boundary the freshly sampled mode decides the WS level of slot 0 bit 0
    w_ws_frame  = ws_calc(tdm_i, w_last_in, '0, '0);
    w_ws_next   = ws_calc(r_tdm, r_last, w_nslot, w_nbit);
  end

  // Run/stop control, SCK generation, position counters and WS
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_dm1    <= '0;
      r_tdm    <= 1'b0;
      r_last   <= SLOT_ONE;
      r_sck    <= 1'b0;
      r_ws     <= WS_POL;
      r_fs     <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_slot   <= '0;
      r_bit    <= '0;
      r_active <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_cnt  <= '0;
      r_sck  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_slot <= '0;
      r_bit  <= '0;
      r_ws   <= w_ws_idle;
      if (en_i) begin
        // Start: slot 0 bit 0 begins now; the first rise comes D clocks later
        r_state  <= ST_RUN;
        r_dm1    <= w_dm1_in;
        r_tdm    <= tdm_i;
        r_last   <= w_last_in;
        r_fs     <= 1'b1;
        r_active <= 1'b1;
      end else begin
        r_fs     <= 1'b0;
        r_active <= 1'b0;
      end
    end else begin
      r_fs   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;

      if (r_state == ST_RUN && !en_i) begin
        r_state <= ST_STOP_PEND;
      end else if (r_state == ST_STOP_PEND && en_i) begin
        r_state <= ST_RUN;
      end

      if (w_term) begin
        r_cnt  <= '0;
        r_sck  <= ~r_sck;
        r_rise <= ~r_sck;
        r_fall <= r_sck;
        if (r_sck) begin
          r_bit  <= w_nbit;
          r_slot <= w_nslot;
          if (w_stop) begin
            // The pending stop takes effect on the boundary fall instead of a new frame starting
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
            r_ws     <= w_ws_idle;
          end else if (w_boundary) begin
            r_fs   <= 1'b1;
            r_dm1  <= w_dm1_in;
            r_tdm  <= tdm_i;
            r_last <= w_last_in;
            r_ws   <= w_ws_frame;
          end else begin
            r_ws <= w_ws_next;
          end
        end
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

  assign sck_o         = r_sck;
  assign ws_o          = r_ws;
  assign frame_start_o = r_fs;
  assign sck_rise_o    = r_rise;
  assign sck_fall_o    = r_fall;
  assign slot_o        = r_slot;
  assign bit_o         = r_bit;
  assign active_o      = r_active;

endmodule

// File: tb/tb_i2s_tdm_clock_gen.sv
// Directed testbench for i2s_tdm_clock_gen (default parameters, WS_POL=0).
// The output vector is {sck, ws, fs, rise, fall, active, slot[2:0], bit[4:0]}.
// Expected values come from closed-form timing relative to the last start.
module tb_i2s_tdm_clock_gen;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic [7:0] div_i;
  logic       tdm_i;
  logic [2:0] nslots_m1_i;
  logic       sck_o;
  logic       ws_o;
  logic       frame_start_o;
  logic       sck_rise_o;
  logic       sck_fall_o;
  logic [2:0] slot_o;
  logic [4:0] bit_o;
  logic       active_o;

  int errors = 0;
  int checks = 0;

  i2s_tdm_clock_gen #(
    .DIV_W(8),
    .SLOT_BITS(32),
    .MAX_SLOTS(8),
    .WS_POL(1'b0)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .en_i(en_i),
    .div_i(div_i),
    .tdm_i(tdm_i),
    .nslots_m1_i(nslots_m1_i),
    .sck_o(sck_o),
    .ws_o(ws_o),
    .frame_start_o(frame_start_o),
    .sck_rise_o(sck_rise_o),
    .sck_fall_o(sck_fall_o),
    .slot_o(slot_o),
    .bit_o(bit_o),
    .active_o(active_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [13:0] act_vec();
    return {sck_o, ws_o, frame_start_o, sck_rise_o, sck_fall_o, active_o, slot_o, bit_o};
  endfunction

  // k: clocks since the frame_start pulse that began counting (k=0 is that pulse).
  // d: effective half period, n: slots per frame, from_idle: k=0 was a start from IDLE.
  function automatic logic [13:0] exp_vec(int k, int d, bit tdm, int n, bit from_idle);
    int p;
    int frame;
    int kf;
    logic sck, ws, fs, rise, fall;
    logic [2:0] slot;
    logic [4:0] bitn;
    p     = 2 * d;
    frame = 32 * p * n;
    kf    = k % frame;
    sck   = (k % p) >= d;
    rise  = (k % p) == d;
    fall  = ((k % p) == 0) && !(from_idle && k == 0);
    fs    = (kf == 0);
    bitn  = 5'((kf / p) % 32);
    slot  = 3'(kf / (32 * p));
    if (tdm) ws = (kf >= frame - p);
    else     ws = (((kf + p) / (32 * p)) % 2) == 1;
    return {sck, ws, fs, rise, fall, 1'b1, slot, bitn};
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0; en_i = 1'b0; div_i = 8'd4; tdm_i = 1'b0; nslots_m1_i = 3'd0;
    tick(); tick();
    checks++; if (sck_o !== 1'b0) begin errors++; $display("FAIL reset_sck got=%b exp=0", sck_o); end
    checks++; if (ws_o !== 1'b0) begin errors++; $display("FAIL reset_ws got=%b exp=0", ws_o); end
    checks++; if (frame_start_o !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", frame_start_o); end
    checks++; if (sck_rise_o !== 1'b0) begin errors++; $display("FAIL reset_rise got=%b exp=0", sck_rise_o); end
    checks++; if (sck_fall_o !== 1'b0) begin errors++; $display("FAIL reset_fall got=%b exp=0", sck_fall_o); end
    checks++; if (slot_o !== 3'd0) begin errors++; $display("FAIL reset_slot got=%0d exp=0", slot_o); end
    checks++; if (bit_o !== 5'd0) begin errors++; $display("FAIL reset_bit got=%0d exp=0", bit_o); end
    checks++; if (active_o !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active_o); end
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (act_vec() !== 14'h0) begin
        errors++; $display("FAIL idle_no_en i=%0d got=%h exp=%h", i, act_vec(), 14'h0);
      end
    end
  endtask

  // I2S, D=4: two frames; div_i moves to 6 mid-frame and must not take effect yet
  task automatic test_i2s();
    en_i = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec(k, 4, 1'b0, 2, 1'b1)) begin
        errors++; $display("FAIL i2s_div4 k=%0d got=%h exp=%h", k, act_vec(), exp_vec(k, 4, 1'b0, 2, 1'b1));
      end
      if (k == 600) div_i = 8'd6;
    end
  endtask

  // New divider applies from the next frame start: SCK period 12
  task automatic test_div_change();
    for (int k = 0; k < 768; k++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec(k, 6, 1'b0, 2, 1'b0)) begin
        errors++; $display("FAIL div_change k=%0d got=%h exp=%h", k, act_vec(), exp_vec(k, 6, 1'b0, 2, 1'b0));
      end
    end
  endtask

  // en_i dropped at slot 0 bit 10; frame completes, then idle; re-enable restarts cleanly
  task automatic test_stop();
    logic [13:0] e;
    for (int k = 0; k < 780; k++) begin
      tick();
      if (k < 768)       e = exp_vec(k, 6, 1'b0, 2, 1'b0);
      else if (k == 768) e = 14'h0200;
      else               e = 14'h0000;
      checks++;
      if (act_vec() !== e) begin
        errors++; $display("FAIL stop k=%0d got=%h exp=%h", k, act_vec(), e);
      end
      if (k == 123) en_i = 1'b0;
    end
    en_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec(k, 6, 1'b0, 2, 1'b1)) begin
        errors++; $display("FAIL restart k=%0d got=%h exp=%h", k, act_vec(), exp_vec(k, 6, 1'b0, 2, 1'b1));
      end
    end
  endtask

  // TDM, D=2, 8 slots: frame of 1024 clks, one-SCK frame-sync before each frame start
  task automatic test_tdm();
    rst_ni = 1'b0;
    tick();
    div_i = 8'd2; tdm_i = 1'b1; nslots_m1_i = 3'd7; en_i = 1'b1;
    rst_ni = 1'b1;
    for (int k = 0; k < 2048; k++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec(k, 2, 1'b1, 8, 1'b1)) begin
        errors++; $display("FAIL tdm k=%0d got=%h exp=%h", k, act_vec(), exp_vec(k, 2, 1'b1, 8, 1'b1));
      end
    end
  endtask

  // div_i=0 behaves as 1: SCK period 2, rise/fall strobes alternate
  task automatic test_div0();
    rst_ni = 1'b0;
    tick();
    div_i = 8'd0; tdm_i = 1'b0; nslots_m1_i = 3'd0; en_i = 1'b1;
    rst_ni = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec(k, 1, 1'b0, 2, 1'b1)) begin
        errors++; $display("FAIL div0 k=%0d got=%h exp=%h", k, act_vec(), exp_vec(k, 1, 1'b0, 2, 1'b1));
      end
    end
  endtask

  // Asynchronous reset between clock edges while running, then a clean restart
  task automatic test_reset_mid();
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (act_vec() !== 14'h0) begin
      errors++; $display("FAIL reset_async got=%h exp=%h", act_vec(), 14'h0);
    end
    tick();
    checks++;
    if (act_vec() !== 14'h0) begin
      errors++; $display("FAIL reset_hold got=%h exp=%h", act_vec(), 14'h0);
    end
    rst_ni = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec(k, 1, 1'b0, 2, 1'b1)) begin
        errors++; $display("FAIL reset_restart k=%0d got=%h exp=%h", k, act_vec(), exp_vec(k, 1, 1'b0, 2, 1'b1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_i2s();
    test_div_change();
    test_stop();
    test_tdm();
    test_div0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
